// File: rtl/jk_cmd_sequencer_if.sv
// jk_cmd_sequencer_if: command FIFO handshake, playback outputs and flop feedback
// for one JK sequencer; master is the command source, slave is the sequencer.
interface jk_cmd_sequencer_if #(parameter int DEPTH = 8, parameter int REP_W = 4);
    logic                     CMD_VALID;
    logic                     CMD_READY;
    logic [1:0]               CMD_OP;
    logic [REP_W-1:0]         CMD_REP;
    logic                     START;
    logic                     J;
    logic                     K;
    logic                     Q_FB;
    logic                     BUSY;
    logic                     DONE;
    logic                     ERR;
    logic                     EXP_Q;
    logic [$clog2(DEPTH):0]   COUNT;
    modport master (output CMD_VALID, CMD_OP, CMD_REP, START, Q_FB,
                    input  CMD_READY, J, K, BUSY, DONE, ERR, EXP_Q, COUNT);
    modport slave  (input  CMD_VALID, CMD_OP, CMD_REP, START, Q_FB,
                    output CMD_READY, J, K, BUSY, DONE, ERR, EXP_Q, COUNT);
endinterface

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queues JK commands and plays them onto one JK flop, one per clock.
// Define JK_SEQ_CHECK_EN to build the expected-Q model and sticky ERR compare.
module jk_cmd_sequencer #(
    parameter int DEPTH = 8,
    parameter int REP_W = 4
) (
    input logic              CLK,
    input logic              RST,
    jk_cmd_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t              state_q, state_d;
    logic [REP_W+1:0]    mem_q [DEPTH];
    logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]         count_q, count_d;
    logic [REP_W-1:0]    rep_q, rep_d;
    logic                j_q, j_d, k_q, k_d, busy_q, busy_d, done_q, done_d;
    logic                full, empty, push, load;
    logic [REP_W+1:0]    head;
    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign push  = bus.CMD_VALID && !full;
    assign head  = mem_q[rd_q];
    // a load pops the head: on an accepted START, or back-to-back when the current op expires
    always_comb begin
        load     = !empty && (state_q == IDLE ? bus.START : state_q == RUN && rep_q == '0);
        state_d  = load ? RUN : state_q == RUN ? (rep_q != '0 ? RUN : FIN) : IDLE;
        {j_d, k_d} = load ? head[REP_W +: 2] : state_d == RUN ? {j_q, k_q} : 2'b00;
        rep_d    = load ? head[REP_W-1:0] : state_q == RUN ? rep_q - REP_W'(1) : rep_q;
        busy_d   = state_d == RUN;
        done_d   = state_d == FIN;
        wr_d     = wr_q + AW'(push);
        rd_d     = rd_q + AW'(load);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(load);
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            rep_q   <= '0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            rep_q   <= rep_d;
            j_q     <= j_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_q] <= {bus.CMD_OP, bus.CMD_REP};
    end
    assign bus.CMD_READY = !full;
    assign bus.J         = j_q;
    assign bus.K         = k_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.COUNT     = count_q;
`ifdef JK_SEQ_CHECK_EN
    logic exp_q, exp_d, err_q, err_d;
    // in IDLE the flop sees J=K=0, so tracking Q_FB keeps the model aligned with the unreset flop
    always_comb begin
        exp_d = state_q == IDLE ? bus.Q_FB : (j_q & !exp_q) | (!k_q & exp_q);
        err_d = (state_q == IDLE && load) ? 1'b0 : err_q | (state_q != IDLE && exp_q != bus.Q_FB);
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            exp_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            exp_q <= exp_d;
            err_q <= err_d;
        end
    end
    assign bus.EXP_Q = exp_q;
    assign bus.ERR   = err_q;
`else
    assign bus.EXP_Q = 1'b0;
    assign bus.ERR   = 1'b0;
`endif
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb_jk_cmd_sequencer: drives commands into jk_cmd_sequencer against a behavioural JK flop,
// scoreboarding the J/K stream and checking FIFO, handshake and check-logic corners.
module tb_jk_cmd_sequencer;
`ifdef JK_SEQ_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    logic CLK, RST, q_ff, force_q0;
    int errs, checks, busy_cnt, done_cnt;
    logic [1:0] sb [$];
    logic [1:0] e;
    jk_cmd_sequencer_if #(.DEPTH(8), .REP_W(4)) bus ();
    jk_cmd_sequencer #(.DEPTH(8), .REP_W(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));
    typedef struct { logic [1:0] op; logic [3:0] rep; logic q_end; int busy; } vec_t;
    vec_t vt [6];
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    initial q_ff = 1'b0;
    always @(posedge CLK) q_ff <= (bus.J & !q_ff) | (!bus.K & q_ff);
    assign bus.Q_FB = force_q0 ? 1'b0 : q_ff;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    always @(posedge CLK) begin
        #2;
        if (bus.DONE) done_cnt++;
        if (bus.BUSY) begin
            busy_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL jk_extra: J,K=%b%b with no expected entry at %0t", bus.J, bus.K, $time);
            end else begin
                e = sb.pop_front();
                chk("jk", {bus.J, bus.K}, e);
            end
        end else chk("jk_idle", {bus.J, bus.K}, 0);
    end
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask
    task automatic push_cmd(input logic [1:0] op, input logic [3:0] rep);
        logic acc;
        bus.CMD_VALID = 1'b1;
        bus.CMD_OP    = op;
        bus.CMD_REP   = rep;
        acc = bus.CMD_READY;
        if (acc) for (int i = 0; i <= int'(rep); i++) sb.push_back(op);
        tick();
        bus.CMD_VALID = 1'b0;
    endtask
    task automatic start();
        busy_cnt = 0;
        done_cnt = 0;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
    endtask
    task automatic wait_done(input int budget);
        int n = 0;
        while (!bus.DONE && n < budget) begin
            tick();
            n++;
        end
        chk("done_timeout", int'(n < budget), 1);
        tick();
        chk("sb_drained", sb.size(), 0);
    endtask
    initial begin
        #500000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end
    initial begin
        vt[0] = '{2'b00, 4'd2,  1'b1, 3};
        vt[1] = '{2'b01, 4'd1,  1'b0, 2};
        vt[2] = '{2'b11, 4'd0,  1'b1, 1};
        vt[3] = '{2'b11, 4'd2,  1'b0, 3};
        vt[4] = '{2'b10, 4'd0,  1'b1, 1};
        vt[5] = '{2'b01, 4'd15, 1'b0, 16};
        errs = 0; checks = 0; busy_cnt = 0; done_cnt = 0; force_q0 = 1'b0;
        bus.CMD_VALID = 1'b0; bus.CMD_OP = 2'b00; bus.CMD_REP = 4'd0; bus.START = 1'b0;
        RST = 1'b1;
        tick();
        tick();
        chk("rst_jk", {bus.J, bus.K}, 0);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_done", bus.DONE, 0);
        chk("rst_err", bus.ERR, 0);
        chk("rst_expq", bus.EXP_Q, 0);
        chk("rst_count", bus.COUNT, 0);
        chk("rst_ready", bus.CMD_READY, 1);
        RST = 1'b0;
        tick();
        tick();
        // playback sequence: 01,10,10,10,11,11
        push_cmd(2'b01, 4'd0);
        push_cmd(2'b10, 4'd2);
        push_cmd(2'b11, 4'd1);
        chk("t1_count", bus.COUNT, 3);
        start();
        wait_done(32);
        chk("t1_busy_cycles", busy_cnt, 6);
        chk("t1_done_pulses", done_cnt, 1);
        chk("t1_q", bus.Q_FB, 1);
        chk("t1_expq", bus.EXP_Q, CHK_EN ? 1 : 0);
        chk("t1_err", bus.ERR, 0);
        for (int i = 0; i < 6; i++) begin
            push_cmd(vt[i].op, vt[i].rep);
            start();
            wait_done(64);
            chk("vec_busy", busy_cnt, vt[i].busy);
            chk("vec_done", done_cnt, 1);
            chk("vec_q", bus.Q_FB, vt[i].q_end);
            chk("vec_expq", bus.EXP_Q, CHK_EN ? int'(vt[i].q_end) : 0);
            chk("vec_err", bus.ERR, 0);
        end
        // full FIFO, with pointers already wrapped by earlier traffic
        for (int i = 0; i < 8; i++) push_cmd(2'(i), 4'(i % 2));
        chk("full_count", bus.COUNT, 8);
        chk("full_ready", bus.CMD_READY, 0);
        push_cmd(2'b11, 4'd7);
        chk("full_reject", bus.COUNT, 8);
        start();
        chk("full_first_pop", bus.COUNT, 7);
        chk("full_ready_after", bus.CMD_READY, 1);
        wait_done(64);
        chk("full_busy", busy_cnt, 12);
        chk("full_drain", bus.COUNT, 0);
`ifdef JK_SEQ_CHECK_EN
        // mismatch: flop output pinned low while a set command plays
        push_cmd(2'b10, 4'd3);
        force_q0 = 1'b1;
        tick();
        start();
        chk("mm_err_c1", bus.ERR, 0);
        tick();
        chk("mm_err_c2", bus.ERR, 0);
        tick();
        chk("mm_err_c3", bus.ERR, 1);
        wait_done(32);
        force_q0 = 1'b0;
        tick();
        chk("mm_err_idle", bus.ERR, 1);
        push_cmd(2'b00, 4'd0);
        start();
        chk("mm_err_cleared", bus.ERR, 0);
        wait_done(32);
        chk("mm_err_end", bus.ERR, 0);
`endif
        // seamless extension plus push/pop in the same cycle
        push_cmd(2'b10, 4'd1);
        start();
        push_cmd(2'b01, 4'd0);
        push_cmd(2'b00, 4'd0);
        chk("ext_count_pushpop", bus.COUNT, 1);
        chk("ext_jk", {bus.J, bus.K}, 1);
        wait_done(32);
        chk("ext_busy", busy_cnt, 4);
        chk("ext_done", done_cnt, 1);
        chk("ext_err", bus.ERR, 0);
        // ignored START: empty FIFO, then while busy
        start();
        chk("ign_idle_busy", bus.BUSY, 0);
        chk("ign_idle_count", bus.COUNT, 0);
        tick();
        chk("ign_idle_done", done_cnt, 0);
        push_cmd(2'b11, 4'd3);
        push_cmd(2'b10, 4'd0);
        start();
        chk("ign_run_count0", bus.COUNT, 1);
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        chk("ign_run_count1", bus.COUNT, 1);
        chk("ign_run_jk", {bus.J, bus.K}, 3);
        wait_done(32);
        chk("ign_busy", busy_cnt, 5);
        chk("ign_done", done_cnt, 1);
        // reset in the 2nd cycle of a long toggle
        push_cmd(2'b11, 4'd5);
        push_cmd(2'b10, 4'd0);
        start();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        sb.delete();
        chk("rr_jk", {bus.J, bus.K}, 0);
        chk("rr_busy", bus.BUSY, 0);
        chk("rr_count", bus.COUNT, 0);
        chk("rr_ready", bus.CMD_READY, 1);
        chk("rr_err", bus.ERR, 0);
        tick();
        tick();
        tick();
        chk("rr_no_done", done_cnt, 0);
        chk("rr_idle_busy", bus.BUSY, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/jk_cmd_sequencer.md
Name: jk_cmd_sequencer

Overview:
Upstream driver for a single JK flip-flop stage (inputs J, K; outputs Q, Qn; no reset; rising-edge CLK).
- Queues JK commands (hold/reset/set/toggle, each with a repeat count) in a small FIFO with valid/ready handshake.
- On START, plays the queued commands onto J/K, one per clock.
- Models the flop's expected Q and flags any mismatch against the Q fed back from the flop.

Parameters:
DEPTH, 8, FIFO entries; power of 2, minimum 2.
REP_W, 4, width of repeat count; each command is applied for CMD_REP+1 cycles.

Ports:
CLK  in  1  clock; all state updates on rising edge.
RST  in  1  synchronous reset, active-high.
CMD_VALID  in  1  command offered.
CMD_READY  out  1  FIFO can accept; equals !full.
CMD_OP  in  2  {J,K} encoding: 00 hold, 01 reset, 10 set, 11 toggle.
CMD_REP  in  REP_W  extra repeat cycles (0 means 1 cycle).
START  in  1  begin playback; one-cycle pulse.
J  out  1  registered, to flop J.
K  out  1  registered, to flop K.
Q_FB  in  1  flop Q, fed back.
BUSY  out  1  high in RUN.
DONE  out  1  one-cycle pulse when playback finishes.
ERR  out  1  sticky mismatch flag.
EXP_Q  out  1  modelled flop state.
COUNT  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
Reset values:
- Synchronous reset applies on a CLK edge with RST=1.
- J=K=0, BUSY=0, DONE=0, ERR=0, EXP_Q=0, COUNT=0, CMD_READY=1.
- FIFO is flushed and the state returns to IDLE.
- RST mid-run aborts immediately: J=K=0 from the next cycle and no DONE pulse.

FIFO:
- Push when CMD_VALID && CMD_READY; stores {CMD_OP, CMD_REP}.
- Pop only on a state-machine load.
- Push and pop in the same cycle are allowed when not full; COUNT is unchanged.
- While full, CMD_READY=0 even if a pop occurs in that cycle.
- Read and write pointers wrap modulo DEPTH.

State machine (IDLE, RUN, FIN):
- IDLE:
  - J=K=0; EXP_Q <= Q_FB every cycle, which synchronises the model to the unreset flop.
  - START && COUNT!=0 -> RUN: pop head; J,K <= op; rep_cnt <= rep; ERR cleared.
  - START with empty FIFO is ignored.
- RUN:
  - BUSY=1; J/K held at the current op.
  - rep_cnt decrements each cycle.
  - When rep_cnt==0 and FIFO is non-empty: pop the next command in the same cycle, with no bubble (J/K change directly to the new op).
  - When rep_cnt==0 and FIFO is empty: -> FIN with J=K=0.
  - Commands pushed during RUN extend playback.
  - START is ignored in RUN.
- FIN:
  - DONE=1 for exactly one cycle; J=K=0; then -> IDLE.

Expected-Q model:
- In RUN and FIN, at each edge EXP_Q applies the flop rule to the current registered J,K: 00 hold, 01 -> 0, 10 -> 1, 11 -> ~EXP_Q.
- On the edge entering RUN, the flop still sees J=K=0, so EXP_Q <= Q_FB remains correct.
- Compare EXP_Q vs Q_FB in every cycle spent in RUN or FIN; a mismatch sets ERR at the next edge.
- ERR stays set until RST or an accepted START.

Optional Feature:
JK_SEQ_CHECK_EN:
- Defined: expected-Q model and ERR logic are present, as described above.
- Undefined: EXP_Q and ERR are tied to 0, Q_FB is ignored, and no model or compare logic is synthesised. All other behaviour is identical.

Test Plan:
1. Playback sequence.
   - Setup: pulse RST; flop driven with J=K=0 for 2 cycles; push {01,0},{10,2},{11,1}; pulse START.
   - Required: J,K = 01,10,10,10,11,11 on consecutive cycles, then 00; BUSY high for 6 cycles; DONE one pulse; final Q=EXP_Q=1; ERR=0.
2. Full FIFO.
   - Setup: push 8 commands without START.
   - Required: COUNT=8, CMD_READY=0; a 9th CMD_VALID is not accepted and COUNT stays 8.
   - After START, the first pop leaves COUNT=7.
3. Mismatch detection.
   - Setup: with JK_SEQ_CHECK_EN, hold Q_FB forced at 0 during a {10,3} command.
   - Required: ERR=1 one cycle after the first mismatched cycle; ERR still 1 in IDLE; cleared by the next accepted START.
4. Reset mid-run.
   - Setup: assert RST during the 2nd cycle of {11,5}.
   - Required: next cycle J=K=0, BUSY=0, COUNT=0, DONE never pulses, CMD_READY=1.
5. Seamless extension.
   - Setup: during RUN of {10,1}, push {01,0}.
   - Required: J,K = 10,10,01 with no 00 bubble; single DONE after the last command.
6. Ignored START.
   - Setup: START with empty FIFO; START while BUSY.
   - Required: no state change; no extra pop; COUNT unchanged.
